coax_tx: RTL and testbench
==========================

Name: coax_tx

Overview:
- Transmitter for the 3270 coax link; the transmit-side counterpart of the existing receiver, sharing the same line encoding and start-sequence timing.
- Accepts 10-bit words from the host-side controller through a one-deep holding register.
- Serialises each frame as: start sequence, then words (each sync bit + 10 data bits + parity), then end sequence.
- Drives the single-ended line driver input.

Parameters:
CLOCKS_PER_BIT, 8, clocks per bit cell; must be even and >= 4; half-bit = CLOCKS_PER_BIT/2.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
data  input  10  word to transmit, MSB sent first
strobe  input  1  load data when ready=1
ready  output  1  holding register empty and accepting
tx  output  1  encoded line output, idle 0
active  output  1  high while a frame is on the line
tx_delay  output  1  only with COAX_TX_DELAY_EN (see below)

Behaviour:
- Bit encoding:
  - '1' = low for the first half-bit, high for the second (mid-bit rising edge).
  - '0' = high for the first half-bit, low for the second.
- Reset values: tx=0, active=0, holding empty, state IDLE. ready=0 while reset is asserted and 1 the cycle after.
- Reset mid-frame aborts immediately: tx=0 the next cycle, holding register discarded.
- ready = !holding_valid && state not in {END_BIT, END_HIGH}. It is combinational from registered state.
- strobe && ready captures data into holding. strobe while ready=0 is ignored (word dropped, no error).
- State machine (all outputs registered; tx changes only on half-bit boundaries):
  - IDLE: tx=0, active=0. When holding_valid, go to START; the first half-bit begins the next cycle. strobe at cycle N gives active=1 and tx=0 at N+1.
  - START: five '1' bits.
  - CV_LOW: tx=0 for 3 half-bits.
  - CV_HIGH: tx=1 for 3 half-bits.
  - SYNC: move holding into the shift register at entry (ready rises that cycle), then send a '1' bit.
  - DATA: send 10 bits, MSB first.
  - PARITY: send one bit making the total count of ones over the 10 data bits plus parity even.
  - After PARITY: if holding_valid go to SYNC, otherwise go to END_BIT.
  - END_BIT: send a '0' bit.
  - END_HIGH: tx=1 for CLOCKS_PER_BIT clocks, then go to IDLE with tx=0 and active=0.
- Frame length = 8 bits + 12 bits per word + 2 bits.
- Boundary conditions:
  - A strobe in the same cycle PARITY completes is not seen by that decision; the frame ends.
  - A strobe during SYNC/DATA/PARITY with holding empty extends the frame seamlessly.
  - During END_BIT/END_HIGH ready=0. A new frame starts only from IDLE, at least 1 cycle of tx=0 after END_HIGH.
- Counters:
  - Clock counter within the bit, width clog2(CLOCKS_PER_BIT), wraps at CLOCKS_PER_BIT-1.
  - Bit counter 4 bits.

Optional Feature:
COAX_TX_DELAY_EN:
- Defined: adds the tx_delay output, equal to tx delayed by CLOCKS_PER_BIT/4 clocks (minimum 1) through a shift register. It feeds the line driver pre-emphasis network. Reset value 0.
- Undefined: the port and its logic are absent, and tx timing is unchanged.

Test Plan:
- CLOCKS_PER_BIT=8, strobe data=10'h2A5 in IDLE at cycle 0:
  - Required: active high cycles 1..176, then 0.
  - Required: tx = 5×"0000_1111", then 12 low, 12 high.
  - Required: sync "00001111", data bits 1010100101, parity 1, end "11110000" then 8 high.
- Two words 10'h000 then 10'h3FF, with the second strobe issued when ready rises at SYNC of word 1:
  - Required: parities 0 and 0, no gap between words.
  - Required: active for 8+24+2=34 bits = 272 cycles.
- strobe while ready=0 with a different data value:
  - Required: value not transmitted, frame unchanged.
- Assert reset during DATA bit 4:
  - Required: tx=0, active=0 next cycle; ready=1 after reset releases.
  - Required: a new strobe produces a full start sequence.
- strobe during END_HIGH:
  - Required: ignored, ready=0.
  - A strobe the cycle after IDLE is reached starts a new frame one cycle later.
- COAX_TX_DELAY_EN defined, CLOCKS_PER_BIT=8:
  - Required: tx_delay equals tx shifted by exactly 2 cycles throughout the frame.

Source files
------------

// File: rtl/coax_tx.sv
// 3270 coax transmitter: holding register, start/code-violation sequence, framed words.
// Optional COAX_TX_DELAY_EN adds tx_delay, tx delayed by CLOCKS_PER_BIT/4 clocks.
module coax_tx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       strobe,
  output logic       ready,
  output logic       tx,
  output logic       active
`ifdef COAX_TX_DELAY_EN
  ,
  output logic       tx_delay
`endif
);

  localparam int HALF = CLOCKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLOCKS_PER_BIT);

  typedef enum logic [3:0] {
    IDLE, START, CV_LOW, CV_HIGH, SYNC,
    DATA, PARITY, END_BIT, END_HIGH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      hold_q, hold_d;
  logic            hv_q, hv_d;
  logic [9:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            active_q, active_d;
  logic            last, mid, load;

  // Line code: '1' is low-then-high, '0' is high-then-low.
  function automatic logic enc(input logic b, input logic [CW-1:0] c);
    return (c >= CW'(HALF)) ? b : !b;
  endfunction

  assign last  = (cnt_q == CW'(CLOCKS_PER_BIT - 1));
  assign mid   = (cnt_q == CW'(HALF - 1));
  assign ready = !reset && !hv_q &&
                 (state_q != END_BIT) && (state_q != END_HIGH);
  assign load  = strobe && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (load) begin
      hold_d = data;
      hv_d   = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (hv_q || load) state_d = START;
      end
      START: if (last) begin
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd4) begin
          state_d = CV_LOW;
          bit_d   = '0;
        end
      end
      // Code violation spans three bit cells split at the mid-point of the second.
      CV_LOW: begin
        if (last) bit_d = bit_q + 4'd1;
        if (mid && bit_q == 4'd1) state_d = CV_HIGH;
      end
      CV_HIGH: if (last) begin
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd2) begin
          state_d = SYNC;
          bit_d   = '0;
          shift_d = hold_q;
          par_d   = ^hold_q;
          hv_d    = 1'b0;
        end
      end
      SYNC: if (last) state_d = DATA;
      DATA: if (last) begin
        shift_d = {shift_q[8:0], 1'b0};
        bit_d   = bit_q + 4'd1;
        if (bit_q == 4'd9) begin
          state_d = PARITY;
          bit_d   = '0;
        end
      end
      PARITY: if (last) begin
        if (hv_q) begin
          state_d = SYNC;
          shift_d = hold_q;
          par_d   = ^hold_q;
          hv_d    = 1'b0;
        end else begin
          state_d = END_BIT;
        end
      end
      END_BIT:  if (last) state_d = END_HIGH;
      END_HIGH: if (last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b0;
    unique case (state_d)
      START:    tx_d = enc(1'b1, cnt_d);
      CV_HIGH:  tx_d = 1'b1;
      SYNC:     tx_d = enc(1'b1, cnt_d);
      DATA:     tx_d = enc(shift_d[9], cnt_d);
      PARITY:   tx_d = enc(par_d, cnt_d);
      END_BIT:  tx_d = enc(1'b0, cnt_d);
      END_HIGH: tx_d = 1'b1;
      default:  tx_d = 1'b0;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      hold_q   <= '0;
      hv_q     <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      hold_q   <= hold_d;
      hv_q     <= hv_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      active_q <= active_d;
    end
  end

  assign tx     = tx_q;
  assign active = active_q;

`ifdef COAX_TX_DELAY_EN
  localparam int DLY = (CLOCKS_PER_BIT / 4 < 1) ? 1 : CLOCKS_PER_BIT / 4;
  logic [DLY-1:0] dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= tx_q;
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign tx_delay = dly_q[DLY-1];
`endif

endmodule

// File: tb/tb_coax_tx.sv
// Directed bench for coax_tx at CLOCKS_PER_BIT=8.
// Builds the expected line waveform from the frame format and compares per cycle.
module tb_coax_tx;

  localparam int CPB = 8;
  localparam int HB  = CPB / 2;

  logic       clk;
  logic       reset;
  logic [9:0] data;
  logic       strobe;
  logic       ready;
  logic       tx;
  logic       active;
`ifdef COAX_TX_DELAY_EN
  logic       tx_delay;
`endif

  int chk_cnt;
  int pass_cnt;
  logic exp_q[$];
  logic txh[$];

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .data   (data),
    .strobe (strobe),
    .ready  (ready),
    .tx     (tx),
    .active (active)
`ifdef COAX_TX_DELAY_EN
    ,
    .tx_delay (tx_delay)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input logic lv, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(lv);
  endfunction

  function automatic void enc_push(input logic b);
    push(!b, HB);
    push(b, HB);
  endfunction

  // Strobe w0 now (at a falling edge), then check every cycle of the frame.
  task automatic run_frame(input string nm, input int nw,
                           input logic [9:0] w0, input logic [9:0] w1,
                           input int glitch);
    logic [9:0] w;
    logic       e;
    int         len;
    bit         sent2;
    exp_q.delete();
    repeat (5) enc_push(1'b1);
    push(1'b0, 3 * HB);
    push(1'b1, 3 * HB);
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? w0 : w1;
      enc_push(1'b1);
      for (int b = 9; b >= 0; b--) enc_push(w[b]);
      enc_push(^w);
    end
    enc_push(1'b0);
    push(1'b1, CPB);
    len = CPB * (10 + 12 * nw);
    txh.delete();
    txh.push_back(1'b0);
    txh.push_back(1'b0);
    sent2 = 1'b0;
    strobe = 1'b1;
    data = w0;
    @(negedge clk);
    for (int cyc = 1; cyc <= len + 3; cyc++) begin
      strobe = 1'b0;
      e = (cyc <= exp_q.size()) ? exp_q[cyc-1] : 1'b0;
      txh.push_back(e);
      chk_cnt++;
      if (tx !== e)
        $display("FAIL %s tx cyc %0d got %b want %b", nm, cyc, tx, e);
      else pass_cnt++;
      chk_cnt++;
      if (active !== (cyc <= len))
        $display("FAIL %s active cyc %0d got %b want %b",
                 nm, cyc, active, (cyc <= len));
      else pass_cnt++;
`ifdef COAX_TX_DELAY_EN
      chk_cnt++;
      if (tx_delay !== txh[cyc-1])
        $display("FAIL %s tx_delay cyc %0d got %b want %b",
                 nm, cyc, tx_delay, txh[cyc-1]);
      else pass_cnt++;
`endif
      if (nw == 2 && !sent2 && cyc > 1 && ready === 1'b1) begin
        chk_cnt++;
        if (cyc != 65)
          $display("FAIL %s ready_rise got cyc %0d want 65", nm, cyc);
        else pass_cnt++;
        strobe = 1'b1;
        data = w1;
        sent2 = 1'b1;
      end
      if (cyc == glitch) begin
        chk_cnt++;
        if (ready !== 1'b0)
          $display("FAIL %s ready_busy got %b want 0", nm, ready);
        else pass_cnt++;
        strobe = 1'b1;
        data = ~w0;
      end
      @(negedge clk);
    end
    strobe = 1'b0;
    if (nw == 2) begin
      chk_cnt++;
      if (!sent2)
        $display("FAIL %s second_strobe got none want sent", nm);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    strobe = 1'b0;
    data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({ready, tx, active} !== 3'b000)
      $display("FAIL reset_vals got %b want 000", {ready, tx, active});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({ready, tx, active} !== 3'b100)
      $display("FAIL reset_release got %b want 100", {ready, tx, active});
    else pass_cnt++;
  endtask

  task automatic test_single;
    run_frame("single_2A5", 1, 10'h2A5, 10'h000, 10);
  endtask

  task automatic test_back_to_back;
    run_frame("b2b_000_3FF", 2, 10'h000, 10'h3FF, 0);
  endtask

  task automatic test_reset_mid;
    strobe = 1'b1;
    data = 10'h2A5;
    @(negedge clk);
    strobe = 1'b0;
    repeat (108) @(negedge clk);
    // cycle 109: second half of DATA bit 4 (a '1'), line high
    chk_cnt++;
    if ({tx, active} !== 2'b11)
      $display("FAIL mid_data got %b want 11", {tx, active});
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({ready, tx, active} !== 3'b000)
      $display("FAIL abort got %b want 000", {ready, tx, active});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({ready, tx, active} !== 3'b100)
      $display("FAIL abort_release got %b want 100", {ready, tx, active});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (active !== 1'b0)
      $display("FAIL abort_stays_idle got %b want 0", active);
    else pass_cnt++;
    run_frame("after_abort", 1, 10'h1C3, 10'h000, 0);
  endtask

  task automatic test_end_high;
    strobe = 1'b1;
    data = 10'h155;
    @(negedge clk);
    strobe = 1'b0;
    repeat (169) @(negedge clk);
    chk_cnt++;
    if ({ready, tx, active} !== 3'b011)
      $display("FAIL end_high got %b want 011", {ready, tx, active});
    else pass_cnt++;
    strobe = 1'b1;
    data = 10'h0F0;
    @(negedge clk);
    strobe = 1'b0;
    repeat (6) @(negedge clk);
    chk_cnt++;
    if ({ready, tx, active} !== 3'b100)
      $display("FAIL end_idle got %b want 100", {ready, tx, active});
    else pass_cnt++;
    run_frame("after_end", 1, 10'h0F0, 10'h000, 0);
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_end_high();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
